mem_access_sequencer: RTL and testbench

Parametrised external-access sequencer between the host or bench side and the processor's instruction/data memories. It accepts commands to burst-load words into any of `NUM_MEM` memories, stream a memory window back out, or run the processor for a programmed cycle count. It replaces hand-driven address, write-enable, read-enable and start strobes with valid/ready handshakes, backpressure and a done/error report. It sits beside `top_control` and owns the external address and enable ports of every memory.

---
 rtl/mem_access_sequencer.sv | 177 +++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// External-access sequencer between the host side and the processor memories:
// burst LOAD, windowed READ and timed RUN commands over valid/ready handshakes.
module mem_access_sequencer #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int NUM_MEM = 2,
  parameter int MEM_LAT = 1,
  parameter int LEN_W   = 24,
  parameter int SEL_W   = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [SEL_W-1:0]          cmd_sel,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [LEN_W-1:0]          cmd_len,
  input  logic                      abort,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [NUM_MEM-1:0]        mem_we,
  output logic [NUM_MEM-1:0]        mem_re,
  input  logic [NUM_MEM*DATA_W-1:0] mem_rdata,
  output logic                      proc_start,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int SEL_N = 2 ** SEL_W;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  // Bit k set when select value k names an existing memory.
  localparam logic [SEL_N-1:0] SEL_OK   = SEL_N'((1 << NUM_MEM) - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_READ = 2'b01,
    OP_RUN  = 2'b10,
    OP_BAD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_WAIT,
    S_LD_WRITE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_OUT,
    S_RUN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [LAT_W-1:0]    lat_q;
  logic                err_q;

  logic                accept;
  logic                illegal;
  logic                cnt_last;
  logic                lat_last;
  logic                live;
  logic [NUM_MEM-1:0]  sel_onehot;
  logic [DATA_W-1:0]   rdata_sel;

  assign cmd_ready  = (state_q == S_IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign illegal    = (cmd_op == OP_BAD) || (cmd_len == '0) ||
                      ((cmd_op != OP_RUN) && !SEL_OK[cmd_sel]);
  assign cnt_last   = (cnt_q == LEN_W'(1));
  assign lat_last   = (lat_q == LAT_LAST);
  assign sel_onehot = NUM_MEM'(1) << sel_q;
  assign rdata_sel  = mem_rdata[int'(sel_q)*DATA_W +: DATA_W];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !illegal) begin
          if (cmd_op == OP_LOAD)      state_d = S_LD_WAIT;
          else if (cmd_op == OP_READ) state_d = S_RD_ISSUE;
          else                        state_d = S_RUN;
        end
      end
      S_LD_WAIT:  if (wr_valid) state_d = S_LD_WRITE;
      S_LD_WRITE: state_d = cnt_last ? S_DONE : S_LD_WAIT;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  if (lat_last) state_d = S_RD_OUT;
      S_RD_OUT:   if (rd_ready) state_d = cnt_last ? S_DONE : S_RD_ISSUE;
      S_RUN:      if (cnt_last) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept & illegal;
      if (abort && state_q != S_IDLE) begin
        rdata_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (accept && !illegal) begin
              sel_q  <= cmd_sel;
              addr_q <= cmd_addr;
              cnt_q  <= cmd_len;
            end
          end
          S_LD_WAIT: if (wr_valid) wdata_q <= wr_data;
          S_LD_WRITE: begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - LEN_W'(1);
          end
          S_RD_ISSUE: lat_q <= '0;
          S_RD_WAIT: begin
            lat_q <= lat_q + LAT_W'(1);
            if (lat_last) rdata_q <= rdata_sel;
          end
          S_RD_OUT: begin
            if (rd_ready) begin
              addr_q <= addr_q + ADDR_W'(1);
              cnt_q  <= cnt_q - LEN_W'(1);
            end
          end
          S_RUN: cnt_q <= cnt_q - LEN_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Strobes decode from the state register; abort masks them in the same cycle.
  assign live       = ~abort;
  assign busy       = (state_q != S_IDLE);
  assign wr_ready   = live && (state_q == S_LD_WAIT);
  assign rd_valid   = live && (state_q == S_RD_OUT);
  assign proc_start = live && (state_q == S_RUN);
  assign done       = live && (state_q == S_DONE);
  assign mem_we     = (live && state_q == S_LD_WRITE) ? sel_onehot : '0;
  assign mem_re     = (live && state_q == S_RD_ISSUE) ? sel_onehot : '0;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rd_data    = rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: command table plus directed LOAD, READ, RUN,
// address-wrap, illegal-select, abort and mid-burst reset sequences.
`timescale 1ns/1ps
module tb_mem_access_sequencer;

  localparam logic [1:0] OP_LOAD = 2'b00, OP_READ = 2'b01, OP_RUN = 2'b10, OP_BAD = 2'b11;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_sel;
  logic [8:0]  cmd_addr;
  logic [23:0] cmd_len;
  logic        abort;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_data;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_we, mem_re;
  logic [31:0] mem_rdata;
  logic        proc_start, busy, done, err;

  // Three-memory instance used for the out-of-range select case.
  logic        d3_cmd_valid, d3_cmd_ready;
  logic [1:0]  d3_cmd_op, d3_cmd_sel;
  logic [8:0]  d3_cmd_addr;
  logic [23:0] d3_cmd_len;
  logic        d3_wr_ready, d3_rd_valid, d3_rd_ready;
  logic [15:0] d3_rd_data, d3_mem_wdata;
  logic [8:0]  d3_mem_addr;
  logic [2:0]  d3_mem_we, d3_mem_re;
  logic        d3_proc_start, d3_busy, d3_done, d3_err;

  always #5 clock = ~clock;

  mem_access_sequencer u_dut (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .abort(abort),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .proc_start(proc_start), .busy(busy), .done(done), .err(err)
  );

  mem_access_sequencer #(.NUM_MEM(3)) u_dut3 (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_op(d3_cmd_op), .cmd_sel(d3_cmd_sel),
    .cmd_addr(d3_cmd_addr), .cmd_len(d3_cmd_len), .abort(1'b0),
    .wr_valid(1'b0), .wr_ready(d3_wr_ready), .wr_data(16'h0000),
    .rd_valid(d3_rd_valid), .rd_ready(d3_rd_ready), .rd_data(d3_rd_data),
    .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata), .mem_we(d3_mem_we), .mem_re(d3_mem_re),
    .mem_rdata(48'h0), .proc_start(d3_proc_start), .busy(d3_busy), .done(d3_done), .err(d3_err)
  );

  // Memory models with one cycle of read latency; DRAM word i preloads to 0xD000+i.
  logic [15:0] iram [512];
  logic [15:0] dram [512];
  logic [15:0] iram_q = 16'h0, dram_q = 16'h0;
  assign mem_rdata = {dram_q, iram_q};

  always @(posedge clock) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) begin
        iram[i] <= 16'h0000;
        dram[i] <= 16'hD000 + 16'(i);
      end
    end else begin
      if (mem_we[0]) iram[mem_addr] <= mem_wdata;
      if (mem_we[1]) dram[mem_addr] <= mem_wdata;
      if (mem_re[0]) iram_q <= iram[mem_addr];
      if (mem_re[1]) dram_q <= dram[mem_addr];
    end
  end

  // Monitor: every event is logged with the index of the cycle it occupied.
  typedef struct { logic [1:0] we; logic [8:0] addr; logic [15:0] data; int cyc; } wr_ev_t;
  typedef struct { logic [15:0] data; int cyc; } hs_ev_t;
  wr_ev_t wr_log[$];
  hs_ev_t hs_log[$];
  int done_log[$], ps_rise[$], rv_rise[$];
  int cyc = 0, err_cnt = 0, re_cnt = 0, ps_cnt = 0, ps_last = 0, busy_cnt = 0;
  int viol_cnt = 0, unstable_cnt = 0;
  logic ps_prev = 1'b0, rv_prev = 1'b0, hold_pend = 1'b0;
  logic [15:0] hold_val = 16'h0;

  always @(posedge clock) begin
    if (mem_we != 2'b00) wr_log.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata, cyc: cyc});
    if (mem_re != 2'b00) re_cnt <= re_cnt + 1;
    if (proc_start) begin
      ps_cnt  <= ps_cnt + 1;
      ps_last <= cyc;
    end
    if (proc_start && !ps_prev) ps_rise.push_back(cyc);
    if (rd_valid && !rv_prev) rv_rise.push_back(cyc);
    if (rd_valid && rd_ready) hs_log.push_back('{data: rd_data, cyc: cyc});
    if (done) done_log.push_back(cyc);
    if (err) err_cnt <= err_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if ($countones(mem_we) > 1 || $countones(mem_re) > 1 || (mem_we != 2'b00 && mem_re != 2'b00))
      viol_cnt <= viol_cnt + 1;
    if (hold_pend && rd_valid && rd_data !== hold_val) unstable_cnt <= unstable_cnt + 1;
    hold_pend <= rd_valid && !rd_ready;
    hold_val  <= rd_data;
    ps_prev   <= proc_start;
    rv_prev   <= rd_valid;
    cyc       <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the next negedge.
  task automatic issue_cmd(input logic [1:0] op, input logic sel, input logic [8:0] addr,
                           input logic [23:0] len, output int acc);
    cmd_op = op; cmd_sel = sel; cmd_addr = addr; cmd_len = len;
    cmd_valid = 1'b1;
    acc = cyc;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_idle_timeout"}, busy, 0);
  endtask

  logic [15:0] words [4];

  task automatic load_words(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 100) begin
      wr_valid = 1'b1;
      wr_data  = words[i];
      if (wr_ready) i++;
      @(negedge clock);
      guard++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_re"}, mem_re, 0);
    check({tag, "_proc_start"}, proc_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        sel;
    logic [8:0]  addr;
    logic [23:0] len;
    int e_err, e_done, e_busy, e_we, e_re, e_ps;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int acc, b_err, b_done, b_busy, b_we, b_re, b_ps, b_hs, b_rv, b_pr, b_un, n;
    rst_n = 1'b0; abort = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_sel = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    d3_cmd_valid = 1'b0; d3_cmd_op = 2'b00; d3_cmd_sel = 2'b00; d3_cmd_addr = '0;
    d3_cmd_len = '0; d3_rd_ready = 1'b0;

    //          op       sel   addr    len    err done busy we re ps
    vecs[0] = '{OP_RUN,  1'b0, 9'd0,   24'd5, 0, 1, 6, 0, 0, 5};
    vecs[1] = '{OP_BAD,  1'b0, 9'd0,   24'd4, 1, 0, 0, 0, 0, 0};
    vecs[2] = '{OP_LOAD, 1'b0, 9'd7,   24'd0, 1, 0, 0, 0, 0, 0};
    vecs[3] = '{OP_READ, 1'b1, 9'd7,   24'd0, 1, 0, 0, 0, 0, 0};
    vecs[4] = '{OP_RUN,  1'b0, 9'd0,   24'd1, 0, 1, 2, 0, 0, 1};
    vecs[5] = '{OP_LOAD, 1'b1, 9'd100, 24'd2, 0, 1, 5, 2, 0, 0};
    vecs[6] = '{OP_READ, 1'b0, 9'd1,   24'd2, 0, 1, 7, 0, 2, 0};
    vecs[7] = '{OP_RUN,  1'b1, 9'd0,   24'd3, 0, 1, 4, 0, 0, 3};

    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // Command table with wr_valid and rd_ready held high.
    for (int i = 0; i < 8; i++) begin
      b_err = err_cnt; b_done = done_log.size(); b_busy = busy_cnt;
      b_we = wr_log.size(); b_re = re_cnt; b_ps = ps_cnt;
      wr_valid = 1'b1; wr_data = 16'h5A5A; rd_ready = 1'b1;
      issue_cmd(vecs[i].op, vecs[i].sel, vecs[i].addr, vecs[i].len, acc);
      wait_idle(200, $sformatf("vec%0d", i));
      repeat (2) @(negedge clock);
      wr_valid = 1'b0; rd_ready = 1'b0;
      check($sformatf("vec%0d_err", i),  err_cnt - b_err, vecs[i].e_err);
      check($sformatf("vec%0d_done", i), done_log.size() - b_done, vecs[i].e_done);
      check($sformatf("vec%0d_busy", i), busy_cnt - b_busy, vecs[i].e_busy);
      check($sformatf("vec%0d_we", i),   wr_log.size() - b_we, vecs[i].e_we);
      check($sformatf("vec%0d_re", i),   re_cnt - b_re, vecs[i].e_re);
      check($sformatf("vec%0d_ps", i),   ps_cnt - b_ps, vecs[i].e_ps);
    end

    // LOAD IRAM @1, three words, wr_valid held high.
    b_we = wr_log.size(); b_done = done_log.size();
    issue_cmd(OP_LOAD, 1'b0, 9'd1, 24'd3, acc);
    check("ld_first_wr_ready", wr_ready, 1);
    words[0] = 16'd10; words[1] = 16'd20; words[2] = 16'd30; words[3] = 16'd0;
    load_words(3);
    wait_idle(50, "ld");
    repeat (2) @(negedge clock);
    check("ld_write_count", wr_log.size() - b_we, 3);
    for (int k = 0; k < 3; k++) begin
      if (b_we + k < wr_log.size()) begin
        check($sformatf("ld_we_%0d", k),   wr_log[b_we+k].we, 2'b01);
        check($sformatf("ld_addr_%0d", k), wr_log[b_we+k].addr, 1 + k);
        check($sformatf("ld_data_%0d", k), wr_log[b_we+k].data, 10 * (k + 1));
        check($sformatf("ld_cyc_%0d", k),  wr_log[b_we+k].cyc, acc + 2 + 2 * k);
      end
    end
    check("ld_done_count", done_log.size() - b_done, 1);
    if (done_log.size() > b_done) check("ld_done_cyc", done_log[b_done], acc + 7);

    // LOAD across the top address: 511 then 0.
    b_we = wr_log.size();
    issue_cmd(OP_LOAD, 1'b0, 9'd511, 24'd2, acc);
    words[0] = 16'h1111; words[1] = 16'h2222;
    load_words(2);
    wait_idle(50, "wrap");
    repeat (2) @(negedge clock);
    check("wrap_write_count", wr_log.size() - b_we, 2);
    if (wr_log.size() >= b_we + 2) begin
      check("wrap_addr_0", wr_log[b_we].addr, 511);
      check("wrap_addr_1", wr_log[b_we+1].addr, 0);
    end
    check("wrap_iram_511", iram[511], 16'h1111);
    check("wrap_iram_0", iram[0], 16'h2222);

    // READ DRAM @5, four words, rd_ready toggling every cycle.
    b_hs = hs_log.size(); b_done = done_log.size(); b_rv = rv_rise.size();
    b_re = re_cnt; b_un = unstable_cnt;
    rd_ready = 1'b0;
    issue_cmd(OP_READ, 1'b1, 9'd5, 24'd4, acc);
    n = 0;
    while (hs_log.size() - b_hs < 4 && n < 200) begin
      rd_ready = ~rd_ready;
      @(negedge clock);
      n++;
    end
    rd_ready = 1'b0;
    wait_idle(50, "rd");
    repeat (2) @(negedge clock);
    check("rd_hs_count", hs_log.size() - b_hs, 4);
    for (int k = 0; k < 4; k++)
      if (b_hs + k < hs_log.size())
        check($sformatf("rd_data_%0d", k), hs_log[b_hs+k].data, 16'hD005 + 16'(k));
    check("rd_stable", unstable_cnt - b_un, 0);
    check("rd_re_count", re_cnt - b_re, 4);
    if (rv_rise.size() > b_rv) check("rd_first_valid_cyc", rv_rise[b_rv], acc + 3);
    check("rd_done_count", done_log.size() - b_done, 1);
    if (done_log.size() > b_done && hs_log.size() >= b_hs + 4)
      check("rd_done_cyc", done_log[b_done], hs_log[b_hs+3].cyc + 1);

    // RUN for 1000 cycles.
    b_ps = ps_cnt; b_pr = ps_rise.size(); b_done = done_log.size();
    issue_cmd(OP_RUN, 1'b0, 9'd0, 24'd1000, acc);
    wait_idle(1100, "run");
    repeat (2) @(negedge clock);
    check("run_ps_count", ps_cnt - b_ps, 1000);
    check("run_ps_rises", ps_rise.size() - b_pr, 1);
    if (ps_rise.size() > b_pr) check("run_ps_first", ps_rise[b_pr], acc + 1);
    check("run_ps_last", ps_last, acc + 1000);
    check("run_done_count", done_log.size() - b_done, 1);
    if (done_log.size() > b_done) check("run_done_cyc", done_log[b_done], acc + 1001);

    // Out-of-range select on the three-memory instance, then a legal sel=2 READ.
    d3_cmd_op = OP_LOAD; d3_cmd_sel = 2'd3; d3_cmd_addr = 9'd0; d3_cmd_len = 24'd4;
    d3_cmd_valid = 1'b1;
    @(negedge clock);
    d3_cmd_valid = 1'b0;
    check("sel3_err", d3_err, 1);
    check("sel3_busy", d3_busy, 0);
    check("sel3_strobes", {d3_mem_we, d3_mem_re, d3_done}, 0);
    @(negedge clock);
    check("sel3_err_one_cycle", d3_err, 0);
    d3_cmd_op = OP_READ; d3_cmd_sel = 2'd2; d3_cmd_len = 24'd1; d3_rd_ready = 1'b1;
    d3_cmd_valid = 1'b1;
    @(negedge clock);
    d3_cmd_valid = 1'b0;
    check("sel2_read_re", d3_mem_re, 3'b100);
    repeat (6) @(negedge clock);
    check("sel2_read_idle", d3_busy, 0);

    // Abort in RD_OUT, then an immediate follow-on command.
    b_done = done_log.size(); b_hs = hs_log.size();
    rd_ready = 1'b0;
    issue_cmd(OP_READ, 1'b1, 9'd20, 24'd8, acc);
    n = 0;
    while (!rd_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ab_reached_rd_out", rd_valid, 1);
    abort = 1'b1;
    #1;
    check("ab_strobes", {rd_valid, wr_ready, proc_start, done, mem_we, mem_re}, 0);
    @(negedge clock);
    abort = 1'b0;
    check("ab_cmd_ready", cmd_ready, 1);
    check("ab_busy", busy, 0);
    issue_cmd(OP_RUN, 1'b0, 9'd0, 24'd2, acc);
    check("ab_next_accepted", {busy, proc_start}, 2'b11);
    wait_idle(20, "ab_run");
    repeat (2) @(negedge clock);
    check("ab_done_count", done_log.size() - b_done, 1);
    check("ab_no_handshake", hs_log.size() - b_hs, 0);

    // Reset asserted while a LOAD word sits in LD_WRITE.
    b_done = done_log.size(); b_we = wr_log.size();
    wr_valid = 1'b0;
    issue_cmd(OP_LOAD, 1'b0, 9'd50, 24'd4, acc);
    check("rst_ld_wait", wr_ready, 1);
    wr_valid = 1'b1; wr_data = 16'hBEEF;
    @(negedge clock);
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (5) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_no_done", done_log.size() - b_done, 0);
    check("rst_no_write", wr_log.size() - b_we, 0);

    check("strobe_onehot", viol_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
